huffman_stream_ctrl: RTL and testbench

Sequencer that feeds the Huffman decoder from a word-oriented bitstream and returns decoded symbols. Accepts 16-bit packed code words, keeps a 32-bit MSB-first bit buffer, presents a 10-bit window to the decoder with a load pulse, consumes the reported code length, and emits symbols on a valid/ready port. Sits between the input word FIFO and the symbol consumer, owning all decoder handshaking.

---
 rtl/huffman_stream_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_huffman_stream_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_stream_ctrl.sv
// huffman_stream_ctrl: MSB-first bit buffer sequencer between a packed word stream and a Huffman decoder.
// Optional macro HUFF_CTRL_STATS_EN enables the sym_count / bits_consumed statistics counters.
module huffman_stream_ctrl #(
    parameter int IN_W  = 16,
    parameter int BUF_W = 32,
    parameter int WIN_W = 10,
    parameter int SYM_W = 5,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIN_W-1:0] dec_window,
    output logic             dec_load,
    input  logic             dec_ready,
    input  logic [SYM_W-1:0] dec_symbol,
    input  logic [LEN_W-1:0] dec_len,
    output logic [SYM_W-1:0] sym_data,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             done,
    output logic             err_len,
    output logic [5:0]       bits_avail,
    output logic [15:0]      sym_count,
    output logic [19:0]      bits_consumed
);
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        S_FILL, S_ISSUE, S_WAIT, S_EMIT, S_HALT, S_DRAIN
    } state_t;

    state_t           state, state_next;
    logic [BUF_W-1:0] bitbuf, buf_next, buf_c;
    logic [CNT_W-1:0] count, count_next, count_c, len_ext;
    logic             last_seen, last_next;
    logic             emitted, emitted_next;
    logic             wait_first;
    logic             sym_valid_q;
    logic [SYM_W-1:0] sym_data_q;
    logic             done_q, err_q;
    logic             accept, can_issue, len_ok, capture, consume, sym_take;
    logic             done_set, err_set, emit_set;

    assign len_ext   = CNT_W'(dec_len);
    assign accept    = in_valid & in_ready;
    assign can_issue = dec_ready & ((count >= CNT_W'(WIN_W)) | (last_seen & (count != '0)));
    assign len_ok    = (dec_len != '0) && (len_ext <= CNT_W'(WIN_W)) && (len_ext <= count);
    assign capture   = (state == S_WAIT) & ~wait_first & dec_ready;
    assign consume   = capture & len_ok;
    assign sym_take  = (state == S_EMIT) & sym_valid_q & sym_ready;

    always_comb begin
        state_next   = state;
        last_next    = last_seen | (accept & in_last);
        emitted_next = emitted | sym_take;
        done_set     = 1'b0;
        err_set      = 1'b0;
        emit_set     = 1'b0;

        // Consume happens before append so the new word lands at the post-consume count.
        buf_c      = consume ? (bitbuf << dec_len) : bitbuf;
        count_c    = consume ? (count - len_ext) : count;
        buf_next   = buf_c;
        count_next = count_c;
        if (accept) begin
            buf_next   = buf_c | ({in_data, {(BUF_W-IN_W){1'b0}}} >> count_c);
            count_next = count_c + CNT_W'(IN_W);
        end

        case (state)
            S_FILL: begin
                if (last_seen && count == '0) begin
                    done_set     = emitted;
                    last_next    = 1'b0;
                    emitted_next = 1'b0;
                end else if (can_issue) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (capture) begin
                    if (len_ok) begin
                        emit_set   = 1'b1;
                        state_next = S_EMIT;
                    end else begin
                        err_set    = 1'b1;
                        state_next = S_HALT;
                    end
                end
            end
            S_EMIT: begin
                if (sym_ready) begin
                    if (last_seen && count == '0) begin
                        done_set     = 1'b1;
                        last_next    = 1'b0;
                        emitted_next = 1'b0;
                        state_next   = S_FILL;
                    end else if (can_issue) begin
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_FILL;
                    end
                end
            end
            S_HALT: state_next = S_HALT;
            S_DRAIN: if (dec_ready && !wait_first) state_next = S_FILL;
            default: state_next = S_FILL;
        endcase

        // A flush while the decoder may still be busy (including an ongoing drain) must drain it.
        if (flush) begin
            buf_next     = '0;
            count_next   = '0;
            last_next    = 1'b0;
            emitted_next = 1'b0;
            done_set     = 1'b0;
            err_set      = 1'b0;
            emit_set     = 1'b0;
            state_next   = (state == S_WAIT || state == S_ISSUE || state == S_DRAIN) ? S_DRAIN : S_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILL;
            bitbuf      <= '0;
            count       <= '0;
            last_seen   <= 1'b0;
            emitted     <= 1'b0;
            wait_first  <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state      <= state_next;
            bitbuf     <= buf_next;
            count      <= count_next;
            last_seen  <= last_next;
            emitted    <= emitted_next;
            wait_first <= (state_next != state);
            done_q     <= done_set;
            if (flush)
                sym_valid_q <= 1'b0;
            else if (emit_set)
                sym_valid_q <= 1'b1;
            else if (sym_take)
                sym_valid_q <= 1'b0;
            if (emit_set)
                sym_data_q <= dec_symbol;
            if (flush)
                err_q <= 1'b0;
            else if (err_set)
                err_q <= 1'b1;
        end
    end

    assign in_ready   = (state != S_HALT) && (state != S_DRAIN) && !last_seen &&
                        (count <= CNT_W'(BUF_W-IN_W)) && !rst;
    assign dec_window = bitbuf[BUF_W-1 -: WIN_W];
    assign dec_load   = (state == S_ISSUE);
    assign sym_valid  = sym_valid_q;
    assign sym_data   = sym_data_q;
    assign done       = done_q;
    assign err_len    = err_q;
    assign bits_avail = count;

`ifdef HUFF_CTRL_STATS_EN
    logic [15:0] sym_cnt_q;
    logic [19:0] bits_q;
    logic [20:0] bits_sum;

    assign bits_sum = {1'b0, bits_q} + 21'(dec_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt_q <= '0;
            bits_q    <= '0;
        end else begin
            if (sym_take && sym_cnt_q != '1)
                sym_cnt_q <= sym_cnt_q + 16'd1;
            if (consume && !flush)
                bits_q <= bits_sum[20] ? '1 : bits_sum[19:0];
        end
    end

    assign sym_count     = sym_cnt_q;
    assign bits_consumed = bits_q;
`else
    assign sym_count     = '0;
    assign bits_consumed = '0;
`endif

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Self-checking bench for huffman_stream_ctrl: reset, directed vectors, corner sequences, random streams.
module tb_huffman_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_last, in_ready;
    logic [15:0] in_data;
    logic [9:0]  dec_window;
    logic        dec_load, dec_ready;
    logic [4:0]  dec_symbol, sym_data;
    logic [3:0]  dec_len;
    logic        sym_valid, sym_ready, done, err_len;
    logic [5:0]  bits_avail;
    logic [15:0] sym_count;
    logic [19:0] bits_consumed;

    always #5 clk = ~clk;

    huffman_stream_ctrl #(.IN_W(16), .BUF_W(32), .WIN_W(10), .SYM_W(5), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .dec_window(dec_window), .dec_load(dec_load), .dec_ready(dec_ready),
        .dec_symbol(dec_symbol), .dec_len(dec_len),
        .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .done(done), .err_len(err_len), .bits_avail(bits_avail),
        .sym_count(sym_count), .bits_consumed(bits_consumed)
    );

    // Decoder model: symbol = top 4 window bits, length fixed or taken from window[9:8]+2.
    int         lat_cfg = 1;
    int         dmode   = 0;
    logic [3:0] fix_len = 4'd4;
    logic       mready;
    logic [4:0] msym;
    logic [3:0] mlen;
    int         mcnt;

    always @(posedge clk) begin
        if (rst) begin
            mready <= 1'b1; mcnt <= 0; msym <= '0; mlen <= '0;
        end else if (dec_load) begin
            mready <= 1'b0;
            mcnt   <= lat_cfg;
            msym   <= {1'b0, dec_window[9:6]};
            mlen   <= (dmode != 0) ? ({2'b00, dec_window[9:8]} + 4'd2) : fix_len;
        end else if (!mready) begin
            if (mcnt <= 1) mready <= 1'b1;
            else mcnt <= mcnt - 1;
        end
    end
    assign dec_ready  = mready;
    assign dec_symbol = msym;
    assign dec_len    = mlen;

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int             n;
        logic [15:0]    w0, w1;
        int             len;
        int             nsym;
        logic [5:0][4:0] s;
        bit             err;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [15:0] w0, input logic [15:0] w1,
                                input int len, input int nsym, input bit err,
                                input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] s3, input logic [4:0] s4);
        vec_t v;
        v.n = n; v.w0 = w0; v.w1 = w1; v.len = len; v.nsym = nsym; v.err = err;
        v.s = {5'h00, s4, s3, s2, s1, s0};
        return v;
    endfunction

    logic [15:0] sw [8];
    int          sn;
    logic [4:0]  exp_q[$];
    logic [4:0]  got_q[$];
    int          exp_err, exp_bits, got_done, loads_after_err;
    bit          got_err, got_fin;
    int          tot_syms = 0, tot_bits = 0;

    // Reference: walk the concatenated bit string directly.
    task automatic ref_model(input int mode, input int flen);
        int T, p, len;
        logic [9:0] win;
        exp_q.delete();
        exp_err = 0;
        T = sn * 16;
        p = 0;
        while (p < T) begin
            for (int k = 0; k < 10; k++)
                win[9-k] = (p + k < T) ? sw[(p+k)/16][15-((p+k)%16)] : 1'b0;
            len = (mode != 0) ? (int'(win[9:8]) + 2) : flen;
            if (len == 0 || len > 10 || len > T - p) begin
                exp_err = 1;
                break;
            end
            exp_q.push_back({1'b0, win[9:6]});
            p += len;
        end
        exp_bits = p;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic run_stream(input bit rnd);
        int wi, cyc, post;
        wi = 0; cyc = 0; post = 0;
        got_q.delete(); got_done = 0; got_err = 0; got_fin = 0; loads_after_err = 0;
        pulse_flush();
        in_valid  = (sn > 0);
        in_data   = sw[0];
        in_last   = (sn == 1);
        sym_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
        while (!got_fin && cyc < 600) begin
            @(negedge clk);
            if (in_valid && in_ready) wi++;
            if (sym_valid && sym_ready) got_q.push_back(sym_data);
            if (done) got_done++;
            if (err_len) begin
                got_err = 1;
                if (dec_load) loads_after_err++;
            end
            if (got_done > 0 || got_err) post++;
            got_fin = (post >= 8);
            @(posedge clk); #1;
            in_valid  = (wi < sn) && (!rnd || $urandom_range(2) != 0);
            in_data   = (wi < sn) ? sw[wi] : 16'h0000;
            in_last   = (wi == sn - 1);
            sym_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("stream_finished", 32'(got_fin), 32'd1);
    endtask

    task automatic check_stream_end(input string tag, input int nsym, input bit err);
        check({tag, "_nsym"}, 32'(got_q.size()), 32'(nsym));
        check({tag, "_err"}, 32'(got_err), 32'(err));
        check({tag, "_done"}, 32'(got_done), err ? 32'd0 : 32'd1);
        check({tag, "_no_load_after_err"}, 32'(loads_after_err), 32'd0);
        @(negedge clk);
        if (err) begin
            check({tag, "_in_ready_halt"}, 32'(in_ready), 32'd0);
            pulse_flush();
            @(negedge clk);
            check({tag, "_err_cleared"}, 32'(err_len), 32'd0);
            check({tag, "_in_ready_flushed"}, 32'(in_ready), 32'd1);
        end else begin
            check({tag, "_bits_avail"}, 32'(bits_avail), 32'd0);
            check({tag, "_in_ready_end"}, 32'(in_ready), 32'd1);
        end
`ifdef HUFF_CTRL_STATS_EN
        check({tag, "_sym_count"}, 32'(sym_count), 32'(tot_syms));
        check({tag, "_bits_consumed"}, 32'(bits_consumed), 32'(tot_bits));
`else
        check({tag, "_sym_count"}, 32'(sym_count), 32'd0);
        check({tag, "_bits_consumed"}, 32'(bits_consumed), 32'd0);
`endif
    endtask

    vec_t vecs [6];

    initial begin
        bit seen;
        vecs[0] = mk(1, 16'hA5F0, 16'h0000, 4, 4, 0, 5'h0A, 5'h05, 5'h0F, 5'h00, 5'h00);
        vecs[1] = mk(1, 16'h8000, 16'h0000, 5, 3, 1, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00);
        vecs[2] = mk(1, 16'hA5F0, 16'h0000, 0, 0, 1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        vecs[3] = mk(2, 16'h1234, 16'hABCD, 8, 4, 0, 5'h01, 5'h03, 5'h0A, 5'h0C, 5'h00);
        vecs[4] = mk(1, 16'hFFFF, 16'h0000, 3, 5, 1, 5'h0F, 5'h0F, 5'h0F, 5'h0F, 5'h0F);
        vecs[5] = mk(2, 16'h3C00, 16'h0000, 10, 3, 1, 5'h03, 5'h00, 5'h00, 5'h00, 5'h00);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sym_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dec_load", 32'(dec_load), 32'd0);
        check("rst_dec_window", 32'(dec_window), 32'd0);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_sym_data", 32'(sym_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_bits_avail", 32'(bits_avail), 32'd0);
        check("rst_sym_count", 32'(sym_count), 32'd0);
        check("rst_bits_consumed", 32'(bits_consumed), 32'd0);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);

        // Consumer stall, then result captured with a word appended the same cycle.
        dmode = 0; fix_len = 4'd4; lat_cfg = 1;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 16'hA5F0;
        @(posedge clk); #1 in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = sym_valid;
        end
        check("stall_sym_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_sym_valid", 32'(sym_valid), 32'd1);
            check("stall_sym_data", 32'(sym_data), 32'h0A);
            check("stall_dec_load", 32'(dec_load), 32'd0);
            check("stall_bits_avail", 32'(bits_avail), 32'd12);
        end
        @(posedge clk); #1 sym_ready = 1'b1;
        tot_syms += 1; tot_bits += 8;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = dec_load;
        end
        check("append_load_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 16'h1234; sym_ready = 1'b0;
        @(negedge clk);
        check("append_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("append_bits_avail", 32'(bits_avail), 32'd24);
        check("append_sym_valid", 32'(sym_valid), 32'd1);
        check("append_sym_data", 32'(sym_data), 32'h05);
        pulse_flush();
        @(negedge clk);
        check("append_flush_sym_valid", 32'(sym_valid), 32'd0);
        check("append_flush_bits", 32'(bits_avail), 32'd0);

        // Slow decoder, flush while waiting.
        lat_cfg = 5; sym_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 16'hA5F0;
        @(posedge clk); #1 in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = dec_load;
        end
        check("drain_load_seen", 32'(seen), 32'd1);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("drain_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            check("drain_sym_valid", 32'(sym_valid), 32'd0);
            check("drain_dec_load", 32'(dec_load), 32'd0);
            check("drain_bits_avail", 32'(bits_avail), 32'd0);
            @(negedge clk);
        end
        check("drain_in_ready_after", 32'(in_ready), 32'd1);
        lat_cfg = 1;

        // Directed vectors.
        for (int v = 0; v < 6; v++) begin
            sn = vecs[v].n; sw[0] = vecs[v].w0; sw[1] = vecs[v].w1;
            dmode = 0; fix_len = 4'(vecs[v].len);
            if (!vecs[v].err) tot_syms += vecs[v].nsym;
            else tot_syms += vecs[v].nsym;
            tot_bits += vecs[v].nsym * vecs[v].len;
            run_stream(0);
            for (int i = 0; i < vecs[v].nsym; i++)
                check($sformatf("vec%0d_sym%0d", v, i),
                      (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(vecs[v].s[i]));
            check_stream_end($sformatf("vec%0d", v), vecs[v].nsym, vecs[v].err);
        end

        // Random streams with variable lengths, throttled input and output.
        for (int r = 0; r < 30; r++) begin
            sn = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) sw[i] = 16'($urandom);
            dmode = 1; lat_cfg = $urandom_range(1, 3);
            ref_model(1, 0);
            tot_syms += exp_q.size();
            tot_bits += exp_bits;
            run_stream(1);
            for (int i = 0; i < exp_q.size(); i++)
                check($sformatf("rnd%0d_sym%0d", r, i),
                      (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
            check_stream_end($sformatf("rnd%0d", r), exp_q.size(), exp_err != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
